sobel_window_feeder: RTL and testbench

//  Streaming producer for the Sobel adder-tree reducer. Takes a raster pixel stream and

---
 rtl/sobel_window_feeder_pkg.sv | 32 +++
 rtl/sobel_window_feeder_line_buffer.sv | 23 ++
 rtl/sobel_window_feeder.sv | 163 ++++++++++++++++
 tb/tb_sobel_window_feeder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sobel_window_feeder_pkg.sv
// Shared constants and helpers for the Sobel window feeder: window geometry,
// gradient coefficients and a shift/negate-only coefficient multiply.
package sobel_pkg;

    localparam int TAP_NUM = 18;
    localparam int WIN     = 3;

    localparam logic signed [2:0] GX [WIN*WIN] = '{
        -3'sd1, 3'sd0, 3'sd1,
        -3'sd2, 3'sd0, 3'sd2,
        -3'sd1, 3'sd0, 3'sd1
    };

    localparam logic signed [2:0] GY [WIN*WIN] = '{
        -3'sd1, -3'sd2, -3'sd1,
         3'sd0,  3'sd0,  3'sd0,
         3'sd1,  3'sd2,  3'sd1
    };

    // Coefficients are limited to {0,+-1,+-2}, so a shift and a negate suffice.
    function automatic logic signed [31:0] tap_mul(input logic [31:0] pix,
                                                   input logic signed [2:0] coef);
        logic signed [31:0] mag;
        mag = signed'(pix);
        if (coef == 3'sd2 || coef == -3'sd2)
            mag = mag <<< 1;
        if (coef == 3'sd0)
            return '0;
        return coef[2] ? -mag : mag;
    endfunction

endpackage

// File: rtl/sobel_window_feeder_line_buffer.sv
// One image row of pixel storage: single address, read-before-write,
// registered read data that holds between accesses.
module line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            dout      <= mem[addr];
            mem[addr] <= din;
        end
    end

endmodule

// File: rtl/sobel_window_feeder.sv
// Raster stream -> 3x3 window -> 18 signed Sobel taps for the adder tree,
// with frame position tracking and a valid flag aligned to the tree output.
module sobel_window_feeder
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH    = 640,
    parameter int IMG_HEIGHT   = 480,
    parameter int PIX_WIDTH    = 8,
    parameter int IN_WIDTH     = 12,
    parameter int TREE_LATENCY = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PIX_WIDTH-1:0]          pix_in,
    input  logic                          pix_valid,
    input  logic                          sof,
    output logic [TAP_NUM*IN_WIDTH-1:0]   taps_out,
    output logic                          taps_valid,
    output logic                          sum_valid,
    output logic [$clog2(IMG_WIDTH)-1:0]  x_out,
    output logic [$clog2(IMG_HEIGHT)-1:0] y_out,
    output logic                          frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic [CW-1:0]           col_reg, col_cur;
    logic [RW-1:0]           row_reg, row_cur;
    logic                    s1_valid_reg, s2_valid_reg;
    logic [PIX_WIDTH-1:0]    s1_pix_reg, s2_pix_reg, s2_up1_reg;
    logic [CW-1:0]           s1_col_reg, s2_col_reg;
    logic [RW-1:0]           s1_row_reg, s2_row_reg;
    logic [PIX_WIDTH-1:0]    lb0_dout, lb1_dout;
    logic [PIX_WIDTH-1:0]    new_col [WIN];
    logic [PIX_WIDTH-1:0]    win_reg [WIN][WIN];
    logic [PIX_WIDTH-1:0]    win_next [WIN][WIN];
    logic [TAP_NUM*IN_WIDTH-1:0] taps_next;
    logic                    interior;
    logic [TREE_LATENCY-1:0] sv_pipe_reg;

    // An accepted sof pixel is (0,0) regardless of where the counters were.
    always_comb begin
        col_cur = sof ? '0 : col_reg;
        row_cur = sof ? '0 : row_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_reg    <= '0;
            row_reg    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= pix_valid && (col_cur == CW'(IMG_WIDTH-1))
                                    && (row_cur == RW'(IMG_HEIGHT-1));
            if (pix_valid) begin
                if (col_cur == CW'(IMG_WIDTH-1)) begin
                    col_reg <= '0;
                    row_reg <= (row_cur == RW'(IMG_HEIGHT-1)) ? '0 : row_cur + RW'(1);
                end else begin
                    col_reg <= col_cur + CW'(1);
                    row_reg <= row_cur;
                end
            end
        end
    end

    // lb1 is refilled one cycle behind lb0, using lb0's read data (the row being evicted).
    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_WIDTH)) u_lb0 (
        .clk  (clk),
        .we   (pix_valid),
        .addr (col_cur),
        .din  (pix_in),
        .dout (lb0_dout)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_WIDTH)) u_lb1 (
        .clk  (clk),
        .we   (s1_valid_reg),
        .addr (s1_col_reg),
        .din  (lb0_dout),
        .dout (lb1_dout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            s1_pix_reg   <= '0;
            s2_pix_reg   <= '0;
            s2_up1_reg   <= '0;
            s1_col_reg   <= '0;
            s2_col_reg   <= '0;
            s1_row_reg   <= '0;
            s2_row_reg   <= '0;
        end else begin
            s1_valid_reg <= pix_valid;
            s2_valid_reg <= s1_valid_reg;
            if (pix_valid) begin
                s1_pix_reg <= pix_in;
                s1_col_reg <= col_cur;
                s1_row_reg <= row_cur;
            end
            if (s1_valid_reg) begin
                s2_pix_reg <= s1_pix_reg;
                s2_up1_reg <= lb0_dout;
                s2_col_reg <= s1_col_reg;
                s2_row_reg <= s1_row_reg;
            end
        end
    end

    always_comb begin
        new_col[0] = lb1_dout;
        new_col[1] = s2_up1_reg;
        new_col[2] = s2_pix_reg;
        win_next   = win_reg;
        if (s2_valid_reg) begin
            for (int r = 0; r < WIN; r++) begin
                win_next[r][0] = win_reg[r][1];
                win_next[r][1] = win_reg[r][2];
                win_next[r][2] = new_col[r];
            end
        end
    end

    // Border windows contain stale or other-row data; only interior ones are emitted.
    assign interior = s2_valid_reg && (s2_row_reg >= RW'(2)) && (s2_col_reg >= CW'(2));

    generate
        for (genvar gi = 0; gi < WIN*WIN; gi++) begin : g_tap
            assign taps_next[(gi+1)*IN_WIDTH-1 -: IN_WIDTH] =
                IN_WIDTH'(tap_mul(32'(win_next[gi/WIN][gi%WIN]), GX[gi]));
            assign taps_next[(gi+WIN*WIN+1)*IN_WIDTH-1 -: IN_WIDTH] =
                IN_WIDTH'(tap_mul(32'(win_next[gi/WIN][gi%WIN]), GY[gi]));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < WIN; r++)
                for (int c = 0; c < WIN; c++)
                    win_reg[r][c] <= '0;
            taps_out    <= '0;
            taps_valid  <= 1'b0;
            x_out       <= '0;
            y_out       <= '0;
            sv_pipe_reg <= '0;
        end else begin
            win_reg     <= win_next;
            taps_valid  <= interior;
            sv_pipe_reg <= {sv_pipe_reg[TREE_LATENCY-2:0], taps_valid};
            if (interior) begin
                taps_out <= taps_next;
                x_out    <= s2_col_reg - CW'(1);
                y_out    <= s2_row_reg - RW'(1);
            end
        end
    end

    assign sum_valid = sv_pipe_reg[TREE_LATENCY-1];

endmodule

// File: tb/tb_sobel_window_feeder.sv
// Directed bench for sobel_window_feeder on a 4x4 image: table of frames with
// expected gradient sums, a pixel-level reference for every tap, plus reset/abort sequences.
module tb_sobel_window_feeder;

    localparam int W = 4, H = 4, PW = 8, IW = 12, TL = 6;
    localparam int TW = 18*IW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] pix_in = '0;
    logic          pix_valid = 1'b0;
    logic          sof = 1'b0;
    logic [TW-1:0] taps_out;
    logic          taps_valid, sum_valid, frame_done;
    logic [1:0]    x_out, y_out;

    sobel_window_feeder #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_WIDTH(PW), .IN_WIDTH(IW), .TREE_LATENCY(TL)
    ) dut (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
        .taps_out(taps_out), .taps_valid(taps_valid), .sum_valid(sum_valid),
        .x_out(x_out), .y_out(y_out), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pat;      // 0: constant 100, 1: ramp 10*col, 2: rows 0..1 = 0, rows 2..3 = 255
        bit gaps;
        int gx_sum;
        int gy_sum;
    } vec_t;

    vec_t vecs[4];
    int   GXB[9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    int   GYB[9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
    int   CONST_TAPS[9] = '{-100, 0, 100, -200, 0, 200, -100, 0, 100};

    int errors = 0, checks = 0;
    int cyc = 0, sv_cnt = 0, fd_cnt = 0;
    logic [TW-1:0] tq[$];
    int xq[$], yq[$], tcq[$], scq[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (taps_valid) begin
                tq.push_back(taps_out);
                xq.push_back(int'(x_out));
                yq.push_back(int'(y_out));
                tcq.push_back(cyc);
            end
            if (sum_valid) begin
                sv_cnt++;
                scq.push_back(cyc);
            end
            if (frame_done) fd_cnt++;
        end
    end

    function automatic int pix_of(int pat, int x, int y);
        case (pat)
            0:       return 100;
            1:       return 10*x;
            default: return (y >= 2) ? 255 : 0;
        endcase
    endfunction

    function automatic int tap_at(logic [TW-1:0] t, int k);
        logic signed [IW-1:0] v;
        v = t[k*IW +: IW];
        return int'(v);
    endfunction

    function automatic logic [TW-1:0] model_taps(int pat, int cx, int cy);
        logic [TW-1:0] res;
        int p;
        res = '0;
        for (int k = 0; k < 9; k++) begin
            p = pix_of(pat, cx - 1 + k%3, cy - 1 + k/3);
            res[k*IW +: IW]     = IW'(GXB[k]*p);
            res[(9+k)*IW +: IW] = IW'(GYB[k]*p);
        end
        return res;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_taps(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        pix_valid = 1'b0;
        sof = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic drive_pix(input int v, input bit s);
        pix_in = PW'(v);
        sof = s;
        pix_valid = 1'b1;
        @(posedge clk); #1;
        pix_valid = 1'b0;
        sof = 1'b0;
    endtask

    task automatic clear_obs();
        tq.delete(); xq.delete(); yq.delete(); tcq.delete(); scq.delete();
        sv_cnt = 0;
        fd_cnt = 0;
    endtask

    task automatic send_frame(input int pat, input bit gaps);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                if (gaps) repeat ($urandom_range(0, 2)) idle();
                drive_pix(pix_of(pat, x, y), (x == 0 && y == 0));
            end
        repeat (16) idle();
    endtask

    task automatic check_frame(input vec_t v, input int idx);
        int gxs, gys;
        chk($sformatf("f%0d win_count", idx), tq.size(), 4);
        chk($sformatf("f%0d frame_done", idx), fd_cnt, 1);
        chk($sformatf("f%0d sum_valid_cnt", idx), sv_cnt, 4);
        if (tcq.size() > 0 && scq.size() > 0)
            chk($sformatf("f%0d sum_valid_lag", idx), scq[0] - tcq[0], TL);
        for (int i = 0; i < tq.size() && i < 4; i++) begin
            chk($sformatf("f%0d w%0d x", idx, i), xq[i], 1 + i%2);
            chk($sformatf("f%0d w%0d y", idx, i), yq[i], 1 + i/2);
            chk_taps($sformatf("f%0d w%0d taps", idx, i), tq[i], model_taps(v.pat, 1 + i%2, 1 + i/2));
            gxs = 0;
            gys = 0;
            for (int k = 0; k < 9; k++) begin
                gxs += tap_at(tq[i], k);
                gys += tap_at(tq[i], 9 + k);
            end
            chk($sformatf("f%0d w%0d gx_sum", idx, i), gxs, v.gx_sum);
            chk($sformatf("f%0d w%0d gy_sum", idx, i), gys, v.gy_sum);
            if (v.pat == 0)
                for (int k = 0; k < 9; k++)
                    chk($sformatf("f%0d w%0d const_tap%0d", idx, i, k), tap_at(tq[i], k), CONST_TAPS[k]);
            if (v.pat == 2 && i < 2) begin
                chk($sformatf("f%0d w%0d gy_tap15", idx, i), int'(tq[i][15*IW +: IW]), 'h0FF);
                chk($sformatf("f%0d w%0d gy_tap16", idx, i), int'(tq[i][16*IW +: IW]), 'h1FE);
                chk($sformatf("f%0d w%0d gy_tap17", idx, i), int'(tq[i][17*IW +: IW]), 'h0FF);
            end
        end
    endtask

    initial begin
        int seen;
        vecs[0] = '{pat: 0, gaps: 1'b0, gx_sum: 0,  gy_sum: 0};
        vecs[1] = '{pat: 1, gaps: 1'b0, gx_sum: 80, gy_sum: 0};
        vecs[2] = '{pat: 0, gaps: 1'b1, gx_sum: 0,  gy_sum: 0};
        vecs[3] = '{pat: 2, gaps: 1'b0, gx_sum: 0,  gy_sum: 1020};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset taps_valid", int'(taps_valid), 0);
        chk("reset sum_valid", int'(sum_valid), 0);

        // Reset asserted for two cycles while pixels are still streaming.
        for (int i = 0; i < 12; i++)
            drive_pix(pix_of(1, i%W, i/W), (i == 0));
        rst = 1'b1;
        pix_valid = 1'b1;
        pix_in = 8'h55;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        pix_valid = 1'b0;
        chk_taps("rst taps_out", taps_out, '0);
        chk("rst flags", int'({taps_valid, sum_valid, frame_done}), 0);
        chk("rst xy", int'({x_out, y_out}), 0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            seen |= int'({taps_valid, sum_valid});
            idle();
        end
        chk("rst quiet after", seen, 0);
        clear_obs();

        for (int v = 0; v < 4; v++) begin
            clear_obs();
            send_frame(vecs[v].pat, vecs[v].gaps);
            check_frame(vecs[v], v);
        end

        // Abort after six ramp pixels; the following frame must be unaffected.
        clear_obs();
        for (int i = 0; i < 6; i++)
            drive_pix(pix_of(1, i%W, i/W), (i == 0));
        send_frame(0, 1'b0);
        check_frame(vecs[0], 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
